if_stage_fetch: RTL and testbench
=================================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage with an integrated IF/ID pipeline register.
- Holds the PC and runs a req/ready handshake with instruction memory.
- Buffers one returned word when ID stalls, and redirects on a taken branch.
- Outputs ID_Inst_org / ID_PC4 / ID_Valid go straight into the ID stage's branch-flush mux, which zeroes the instruction combinationally on Branch. This block then inserts the bubble in the register on the following edge.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored (forced 00).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low (one clock domain; polarity and synchronicity fixed)
- Stall  in  1  hazard unit: hold PC and IF/ID contents
- Branch  in  1  taken branch resolved in ID; same signal that drives the ID flush
- Branch_Target  in  32  redirect address; bits [1:0] forced to 00
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  returned instruction word
- ID_Inst_org  out  32  IF/ID instruction (registered)
- ID_PC4  out  32  IF/ID PC+4 of that instruction (registered)
- ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)
- IF_Busy  out  1  high in DROP or HOLD (diagnostic)

Behaviour:
- Reset (rst_n=0, async): PC=RESET_PC, state=FETCH, skid empty, ID_Inst_org=0, ID_PC4=0, ID_Valid=0, imem_req=0 (gated by rst_n), IF_Busy=0.
- State machine:
  - FETCH: imem_req=1, imem_addr=PC.
  - HOLD: imem_req=0; skid holds a word and its PC+4.
  - DROP: imem_req=1, imem_addr=Old_PC (address of the in-flight request); returned word is discarded.
- Priority: Branch > Stall > normal advance.
- Branch=1, any state:
  - PC <= Branch_Target; IF/ID loads a bubble (Inst=0, PC4=0, Valid=0), even if Stall=1; skid cleared.
  - FETCH with ready=0: Old_PC <= PC, go DROP.
  - FETCH with ready=1: word discarded, stay FETCH.
  - HOLD: go FETCH.
  - DROP with ready=1: go FETCH.
  - DROP with ready=0: stay DROP (Old_PC unchanged, PC takes newest target).
- FETCH, ready=1, Stall=0: IF/ID <= {imem_rdata, PC+4, Valid=1}; PC <= PC+4.
- FETCH, ready=1, Stall=1: skid <= {imem_rdata, PC+4}; PC <= PC+4; IF/ID held; go HOLD.
- FETCH, ready=0: Stall=0 -> IF/ID <= bubble; Stall=1 -> IF/ID held; PC held.
- HOLD, Stall=0: IF/ID <= {skid, Valid=1}; go FETCH (request for the new PC issues that cycle+1).
- HOLD, Stall=1: everything held.
- DROP, no Branch: ready=1 -> go FETCH; IF/ID <= bubble unless Stall. ready=0 -> wait in DROP.
- Zero-wait memory (ready tied 1): one instruction per cycle; a word fetched at edge N is in IF/ID after edge N.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.
- Reset mid-request: outstanding request abandoned; memory must tolerate req dropping.
- Never more than one request outstanding; never more than one buffered word.

Test Plan:
- Reset, RESET_PC=0, ready=1, rdata=addr+0x100, no stall -> after 3 edges imem_addr=0x0C, ID_Inst_org=0x108, ID_PC4=0x0C, ID_Valid=1.
- Stall high 2 cycles while ready=1 at PC=0x08 -> state HOLD, skid=0x108, PC=0x0C, IF/ID unchanged, imem_req=0. Release stall -> IF/ID=0x108/0x0C, Valid=1, next request at 0x0C.
- ready=0 for 3 cycles, Branch=1 with target 0x40 in first cycle -> DROP, imem_addr stays old PC, IF_Busy=1. On ready: word discarded, next request addr=0x40, ID_Valid=0 until 0x40 returns.
- Branch and Stall together with ready=1, target 0x203 -> PC=0x200, IF/ID bubble (Inst=0, Valid=0), fetched word dropped.
- RESET_PC=32'hFFFF_FFFC, ready=1 -> second request addr=0x0, ID_PC4=0x0 for first word.
- Assert rst_n=0 asynchronously mid-DROP -> all outputs reset immediately without a clock edge; after release, request at RESET_PC.

Source files
------------

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with an integrated IF/ID pipeline register.
// Drives a req/ready instruction memory, buffers one word on stall, redirects on branch.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] Branch_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_Inst_org,
  output logic [31:0] ID_PC4,
  output logic        ID_Valid,
  output logic        IF_Busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_MASK;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_old_pc, w_old_pc_n;
  logic [31:0] r_skid_inst, w_skid_inst_n;
  logic [31:0] r_skid_pc4, w_skid_pc4_n;
  logic [31:0] r_id_inst, w_id_inst_n;
  logic [31:0] r_id_pc4, w_id_pc4_n;
  logic        r_id_valid, w_id_valid_n;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = Branch_Target & PC_MASK;

  // Request is gated by rst_n so it drops the instant reset asserts.
  assign imem_req    = rst_n & (r_state != S_HOLD);
  assign imem_addr   = (r_state == S_DROP) ? r_old_pc : r_pc;
  assign ID_Inst_org = r_id_inst;
  assign ID_PC4      = r_id_pc4;
  assign ID_Valid    = r_id_valid;
  assign IF_Busy     = (r_state != S_FETCH);

  // Next-state and datapath update: Branch beats Stall beats normal advance.
  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_old_pc_n    = r_old_pc;
    w_skid_inst_n = r_skid_inst;
    w_skid_pc4_n  = r_skid_pc4;
    w_id_inst_n   = r_id_inst;
    w_id_pc4_n    = r_id_pc4;
    w_id_valid_n  = r_id_valid;
    if (Branch) begin
      w_pc_n        = w_target;
      w_id_inst_n   = 32'd0;
      w_id_pc4_n    = 32'd0;
      w_id_valid_n  = 1'b0;
      w_skid_inst_n = 32'd0;
      w_skid_pc4_n  = 32'd0;
      case (r_state)
        S_FETCH: begin
          if (!imem_ready) begin
            w_old_pc_n = r_pc;
            w_state_n  = S_DROP;
          end else begin
            w_state_n  = S_FETCH;
          end
        end
        S_HOLD:  w_state_n = S_FETCH;
        S_DROP:  w_state_n = imem_ready ? S_FETCH : S_DROP;
        default: w_state_n = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            w_pc_n = w_pc_plus4;
            if (Stall) begin
              w_skid_inst_n = imem_rdata;
              w_skid_pc4_n  = w_pc_plus4;
              w_state_n     = S_HOLD;
            end else begin
              w_id_inst_n  = imem_rdata;
              w_id_pc4_n   = w_pc_plus4;
              w_id_valid_n = 1'b1;
            end
          end else if (!Stall) begin
            w_id_inst_n  = 32'd0;
            w_id_pc4_n   = 32'd0;
            w_id_valid_n = 1'b0;
          end else begin
            w_id_valid_n = r_id_valid;
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            w_id_inst_n  = r_skid_inst;
            w_id_pc4_n   = r_skid_pc4;
            w_id_valid_n = 1'b1;
            w_state_n    = S_FETCH;
          end else begin
            w_state_n    = S_HOLD;
          end
        end
        S_DROP: begin
          // The in-flight word belongs to the abandoned path and is never used.
          if (imem_ready) begin
            w_state_n = S_FETCH;
            if (!Stall) begin
              w_id_inst_n  = 32'd0;
              w_id_pc4_n   = 32'd0;
              w_id_valid_n = 1'b0;
            end else begin
              w_id_valid_n = r_id_valid;
            end
          end else begin
            w_state_n = S_DROP;
          end
        end
        default: w_state_n = S_FETCH;
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC_ALIGNED;
      r_old_pc    <= 32'd0;
      r_skid_inst <= 32'd0;
      r_skid_pc4  <= 32'd0;
      r_id_inst   <= 32'd0;
      r_id_pc4    <= 32'd0;
      r_id_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_old_pc    <= w_old_pc_n;
      r_skid_inst <= w_skid_inst_n;
      r_skid_pc4  <= w_skid_pc4_n;
      r_id_inst   <= w_id_inst_n;
      r_id_pc4    <= w_id_pc4_n;
      r_id_valid  <= w_id_valid_n;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: directed scenarios, then randomized
// stall/branch/latency traffic checked against an in-order instruction-stream scoreboard.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Branch, imem_ready;
  logic [31:0] Branch_Target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, ID_Inst_org, ID_PC4;
  logic        ID_Valid, IF_Busy;

  logic        req2, valid2, busy2;
  logic [31:0] addr2, rdata2, inst2, pc42;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int pops = 0;

  typedef struct { logic [31:0] inst; logic [31:0] pc4; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] stream_pc;

  always #5 clk = ~clk;

  // Instruction memory model: word at address a is a + 0x100.
  assign imem_rdata = imem_addr + 32'h0000_0100;
  assign rdata2     = addr2 + 32'h0000_0100;

  if_stage_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Branch(Branch),
    .Branch_Target(Branch_Target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ID_Inst_org(ID_Inst_org),
    .ID_PC4(ID_PC4), .ID_Valid(ID_Valid), .IF_Busy(IF_Busy)
  );

  if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .Stall(1'b0), .Branch(1'b0),
    .Branch_Target(32'h0000_0000), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_rdata(rdata2), .ID_Inst_org(inst2),
    .ID_PC4(pc42), .ID_Valid(valid2), .IF_Busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h0000_0100;
  endfunction

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{inst: mem_word(stream_pc), pc4: stream_pc + 32'd4});
      stream_pc = stream_pc + 32'd4;
    end
  endtask

  // Monitor: pops the next expected instruction whenever ID consumes a valid one.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (prev_wait && imem_req) check("addr_stable", imem_addr, prev_addr);
        prev_wait = imem_req && !imem_ready;
        prev_addr = imem_addr;
        if (!ID_Valid) begin
          check("bubble_inst", ID_Inst_org, 32'd0);
          check("bubble_pc4", ID_PC4, 32'd0);
        end else if (!Stall) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("stream_inst", ID_Inst_org, e.inst);
            check("stream_pc4", ID_PC4, e.pc4);
            pops++;
          end
        end
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; Stall = 1'b0; Branch = 1'b0; Branch_Target = 32'd0; imem_ready = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, ID_Valid}, 32'd0);
    check("rst_inst", ID_Inst_org, 32'd0);
    check("rst_pc4", ID_PC4, 32'd0);
    check("rst_busy", {31'd0, IF_Busy}, 32'd0);
    #6 rst_n = 1'b1;                                   // t=7
    @(negedge clk);                                    // t=10
    check("wrap_addr0", addr2, 32'hFFFF_FFFC);
    check("first_addr", imem_addr, 32'd0);
    imem_ready = 1'b1;
    @(negedge clk);                                    // t=20
    check("wrap_addr1", addr2, 32'd0);
    check("wrap_pc4", pc42, 32'd0);
    check("wrap_inst", inst2, 32'h0000_00FC);
    @(negedge clk); @(negedge clk);                    // t=40, three edges
    check("zw_addr", imem_addr, 32'h0C);
    check("zw_inst", ID_Inst_org, 32'h108);
    check("zw_pc4", ID_PC4, 32'h0C);
    check("zw_valid", {31'd0, ID_Valid}, 32'd1);
    Stall = 1'b1;
    @(negedge clk); @(negedge clk);                    // t=60
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_busy", {31'd0, IF_Busy}, 32'd1);
    check("hold_inst", ID_Inst_org, 32'h108);
    Stall = 1'b0;
    @(negedge clk);                                    // t=70
    check("unhold_inst", ID_Inst_org, 32'h10C);
    check("unhold_pc4", ID_PC4, 32'h10);
    check("unhold_addr", imem_addr, 32'h10);
    imem_ready = 1'b0; Branch = 1'b1; Branch_Target = 32'h40;
    @(negedge clk);                                    // t=80
    Branch = 1'b0;
    check("drop_addr", imem_addr, 32'h10);
    check("drop_busy", {31'd0, IF_Busy}, 32'd1);
    check("drop_valid", {31'd0, ID_Valid}, 32'd0);
    @(negedge clk); @(negedge clk);                    // t=100
    check("drop_addr_held", imem_addr, 32'h10);
    imem_ready = 1'b1;
    @(negedge clk);                                    // t=110
    check("redir_addr", imem_addr, 32'h40);
    check("redir_valid", {31'd0, ID_Valid}, 32'd0);
    @(negedge clk);                                    // t=120
    check("target_inst", ID_Inst_org, 32'h140);
    Branch = 1'b1; Stall = 1'b1; Branch_Target = 32'h203;
    @(negedge clk);                                    // t=130
    Branch = 1'b0; Stall = 1'b0;
    check("bs_addr", imem_addr, 32'h200);
    check("bs_inst", ID_Inst_org, 32'd0);
    check("bs_valid", {31'd0, ID_Valid}, 32'd0);
    imem_ready = 1'b0; Branch = 1'b1; Branch_Target = 32'h80;
    @(negedge clk);                                    // t=140, now in DROP
    Branch = 1'b0;
    check("pre_rst_busy", {31'd0, IF_Busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_busy", {31'd0, IF_Busy}, 32'd0);
    check("async_addr", imem_addr, 32'd0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_addr", imem_addr, 32'd0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Randomized phase from a clean reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stream_pc = 32'd0;
    exp_q.delete();
    refill();
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      Stall      = ($urandom_range(0, 3) == 0);
      Branch     = ($urandom_range(0, 9) == 0);
      Branch_Target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : ($urandom & 32'h0000_0FFF);
      #2;
      if (Branch) begin
        exp_q.delete();
        stream_pc = Branch_Target & 32'hFFFF_FFFC;
      end
      refill();
      @(negedge clk);
    end
    mon_en = 1'b0;
    check("liveness", {31'd0, (pops > 300)}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
